uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte FIFO feeding an 8N1 UART serializer. It accepts bytes
//                written to the muarttx CSR and reports the transmit status
//                bits that are read back through muartstat.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int DEPTH        = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_valid,
   input  logic [7:0]                 wr_data,
   output logic                       wr_ready,
   output logic                       tx_empty,
   output logic                       tx_full,
   output logic                       overflow,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       txd
);

   localparam int c_PTR_W  = $clog2(DEPTH);
   localparam int c_CNT_W  = $clog2(DEPTH) + 1;
   localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]          r_mem [DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;
   logic                r_overflow;

   // Serializer state
   state_t              r_state;
   state_t              w_state_next;
   logic [c_BAUD_W-1:0] r_baud;
   logic [c_BAUD_W-1:0] w_baud_next;
   logic [2:0]          r_bit;
   logic [2:0]          w_bit_next;
   logic [7:0]          r_shift;
   logic [7:0]          w_shift_next;
   logic                r_txd;
   logic                w_txd_next;

   logic                w_full;
   logic                w_push;
   logic                w_pop;
   logic                w_baud_done;

   // Acceptance is decided by occupancy at the start of the cycle, so a pop in
   // the same cycle never rescues a write that arrives while full.
   assign w_full      = (r_count == c_CNT_W'(DEPTH));
   assign w_push      = wr_valid && !w_full;
   assign w_baud_done = (r_baud == c_BAUD_W'(CLKS_PER_BIT - 1));

   assign wr_ready = !w_full;
   assign tx_full  = w_full;
   assign tx_empty = (r_count == '0) && (r_state == ST_IDLE);
   assign overflow = r_overflow;
   assign count    = r_count;
   assign txd      = r_txd;

   // Write accepted bytes into the circular buffer (contents need no reset)
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // Pointer, occupancy and sticky overflow tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - c_CNT_W'(1);
         end
         if (wr_valid && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Serializer state register; txd is a flop so the line is glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_txd   <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_baud  <= w_baud_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
         r_txd   <= w_txd_next;
      end
   end

   // Next-state and line-level decode; txd follows the state being entered
   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_txd_next   = 1'b1;
      w_pop        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_baud_next = '0;
            w_bit_next  = '0;
            if (r_count != '0) begin
               w_pop        = 1'b1;
               w_shift_next = r_mem[r_rd_ptr];
               w_state_next = ST_START;
               w_txd_next   = 1'b0;
            end
         end
         ST_START: begin
            w_txd_next = 1'b0;
            if (w_baud_done) begin
               w_baud_next  = '0;
               w_bit_next   = '0;
               w_state_next = ST_DATA;
               w_txd_next   = r_shift[0];
            end else begin
               w_baud_next = r_baud + c_BAUD_W'(1);
            end
         end
         ST_DATA: begin
            w_txd_next = r_shift[0];
            if (w_baud_done) begin
               w_baud_next = '0;
               if (r_bit == 3'd7) begin
                  w_state_next = ST_STOP;
                  w_txd_next   = 1'b1;
               end else begin
                  w_shift_next = {1'b0, r_shift[7:1]};
                  w_bit_next   = r_bit + 3'd1;
                  w_txd_next   = r_shift[1];
               end
            end else begin
               w_baud_next = r_baud + c_BAUD_W'(1);
            end
         end
         ST_STOP: begin
            w_txd_next = 1'b1;
            if (w_baud_done) begin
               w_baud_next  = '0;
               w_state_next = ST_IDLE;
            end else begin
               w_baud_next = r_baud + c_BAUD_W'(1);
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_baud_next  = '0;
         end
      endcase
   end

endmodule
`default_nettype wire
